// File: rtl/rr_merge_nbit_x4.sv
// ============================================================================
// Module   : rr_merge_nbit_x4
// Brief    : Four-channel round-robin merge onto one registered valid/ready
//            stream with source index. Optional per-channel accept counters
//            (cnt_a..cnt_d) are built when RR_MERGE_GRANT_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_merge_nbit_x4 #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef RR_MERGE_GRANT_CNT_EN
  output logic [15:0]          cnt_a,
  output logic [15:0]          cnt_b,
  output logic [15:0]          cnt_c,
  output logic [15:0]          cnt_d,
`endif
  input  logic [BUS_WIDTH-1:0] a,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [BUS_WIDTH-1:0] c,
  input  logic                 c_valid,
  output logic                 c_ready,
  input  logic [BUS_WIDTH-1:0] d,
  input  logic                 d_valid,
  output logic                 d_ready,
  output logic [BUS_WIDTH-1:0] y,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic [1:0]           sel
);

  logic [BUS_WIDTH-1:0] r_y;
  logic                 r_y_valid;
  logic [1:0]           r_sel;
  logic [1:0]           r_rr_ptr;

  logic [3:0]           w_valid;
  logic                 w_load_en;
  logic                 w_found;
  logic [1:0]           w_grant;
  logic                 w_accept;
  logic [BUS_WIDTH-1:0] w_data;

  assign w_valid   = {d_valid, c_valid, b_valid, a_valid};
  assign w_load_en = !r_y_valid || y_ready;

  // First requester at or after the pointer, wrapping modulo 4.
  always_comb begin
    logic [1:0] w_idx;
    w_grant = r_rr_ptr;
    w_found = 1'b0;
    w_idx   = r_rr_ptr;
    for (int i = 0; i < 4; i++) begin
      w_idx = r_rr_ptr + 2'(i);
      if (!w_found && w_valid[w_idx]) begin
        w_grant = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_data = a;
    case (w_grant)
      2'd0:    w_data = a;
      2'd1:    w_data = b;
      2'd2:    w_data = c;
      default: w_data = d;
    endcase
  end

  assign w_accept = w_load_en && w_found && !reset;

  assign a_ready = w_accept && (w_grant == 2'd0);
  assign b_ready = w_accept && (w_grant == 2'd1);
  assign c_ready = w_accept && (w_grant == 2'd2);
  assign d_ready = w_accept && (w_grant == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_sel     <= 2'd0;
      r_rr_ptr  <= 2'd0;
    end else if (w_load_en) begin
      if (w_found) begin
        r_y       <= w_data;
        r_sel     <= w_grant;
        r_y_valid <= 1'b1;
        r_rr_ptr  <= w_grant + 2'd1;
      end else begin
        r_y_valid <= 1'b0;
      end
    end
  end

  assign y       = r_y;
  assign y_valid = r_y_valid;
  assign sel     = r_sel;

`ifdef RR_MERGE_GRANT_CNT_EN
  localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

  logic [15:0] r_cnt [4];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) begin
        r_cnt[i] <= '0;
      end else if (w_accept && (w_grant == 2'(i)) && (r_cnt[i] != c_CNT_MAX)) begin
        r_cnt[i] <= r_cnt[i] + 16'd1;
      end
    end
  end

  assign cnt_a = r_cnt[0];
  assign cnt_b = r_cnt[1];
  assign cnt_c = r_cnt[2];
  assign cnt_d = r_cnt[3];
`endif

endmodule

`default_nettype wire

// File: tb/tb_rr_merge_nbit_x4.sv
// ============================================================================
// Module   : tb_rr_merge_nbit_x4
// Brief    : Directed and random checks of rr_merge_nbit_x4 against a
//            reference model of the merge/round-robin rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_merge_nbit_x4;

  logic       clk;
  logic       reset;
  logic [7:0] din [4];
  logic       vin [4];
  logic [7:0] a, b, c, d;
  logic       a_valid, b_valid, c_valid, d_valid;
  logic       a_ready, b_ready, c_ready, d_ready;
  logic [7:0] y;
  logic       y_valid;
  logic       y_ready;
  logic [1:0] sel;
`ifdef RR_MERGE_GRANT_CNT_EN
  logic [15:0] cnt_a, cnt_b, cnt_c, cnt_d;
`endif

  assign a = din[0];
  assign b = din[1];
  assign c = din[2];
  assign d = din[3];
  assign a_valid = vin[0];
  assign b_valid = vin[1];
  assign c_valid = vin[2];
  assign d_valid = vin[3];

  rr_merge_nbit_x4 #(.BUS_WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
`ifdef RR_MERGE_GRANT_CNT_EN
    .cnt_a   (cnt_a),
    .cnt_b   (cnt_b),
    .cnt_c   (cnt_c),
    .cnt_d   (cnt_d),
`endif
    .a       (a),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .b       (b),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .c       (c),
    .c_valid (c_valid),
    .c_ready (c_ready),
    .d       (d),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .sel     (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // reference model state
  logic [7:0] m_y;
  logic       m_v;
  int         m_sel;
  int         m_ptr;
  int         m_cnt [4];
  logic [3:0] m_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check readies mid-cycle, advance the model, check outputs after the edge.
  task automatic step();
    int  g;
    bit  le;
    #4;
    le = !m_v || (y_ready === 1'b1);
    g  = -1;
    for (int k = 0; k < 4; k++) begin
      if (g < 0 && vin[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    end
    m_rdy = 4'b0;
    if (!reset && le && g >= 0) m_rdy[g] = 1'b1;
    chk("ready", 32'({d_ready, c_ready, b_ready, a_ready}), 32'(m_rdy));
    if (reset) begin
      m_y = 8'h00; m_v = 1'b0; m_sel = 0; m_ptr = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else if (le) begin
      if (g >= 0) begin
        m_y = din[g]; m_sel = g; m_v = 1'b1; m_ptr = (g + 1) % 4;
        if (m_cnt[g] < 65535) m_cnt[g]++;
      end else begin
        m_v = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("y_valid", 32'(y_valid), 32'(m_v));
    if (m_v || reset) begin
      chk("y", 32'(y), 32'(m_y));
      chk("sel", 32'(sel), 32'(m_sel));
    end
`ifdef RR_MERGE_GRANT_CNT_EN
    chk("cnt_a", 32'(cnt_a), 32'(m_cnt[0]));
    chk("cnt_b", 32'(cnt_b), 32'(m_cnt[1]));
    chk("cnt_c", 32'(cnt_c), 32'(m_cnt[2]));
    chk("cnt_d", 32'(cnt_d), 32'(m_cnt[3]));
`endif
  endtask

  task automatic set_in(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3);
    for (int i = 0; i < 4; i++) vin[i] = v[i];
    din[0] = d0; din[1] = d1; din[2] = d2; din[3] = d3;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] held_y;
    m_y = 8'h00; m_v = 1'b0; m_sel = 0; m_ptr = 0; m_rdy = 4'b0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    reset   = 1'b1;
    y_ready = 1'b0;
    set_in(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    @(posedge clk); #1;
    step();
    chk("rst_y_valid", 32'(y_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    reset = 1'b0;

    // single word from a
    set_in(4'b0001, 8'h11, 8'h00, 8'h00, 8'h00);
    y_ready = 1'b1;
    step();
    chk("a_first_y", 32'(y), 32'h11);
    chk("a_first_sel", 32'(sel), 32'd0);
    set_in(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    step();

    // fairness with all four requesting
    do_reset();
    set_in(4'b1111, 8'd1, 8'd2, 8'd3, 8'd4);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_y", 32'(y), 32'((i % 4) + 1));
      chk("rr_sel", 32'(sel), 32'(i % 4));
    end

    // stall with y=22 from b, c waiting
    do_reset();
    set_in(4'b0010, 8'h00, 8'h22, 8'h33, 8'h00);
    step();
    chk("stall_load_y", 32'(y), 32'h22);
    set_in(4'b0100, 8'h00, 8'h22, 8'h33, 8'h00);
    y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_c_ready", 32'(c_ready), 32'd0);
      chk("stall_y", 32'(y), 32'h22);
      chk("stall_sel", 32'(sel), 32'd1);
    end
    y_ready = 1'b1;
    step();
    chk("unstall_y", 32'(y), 32'h33);
    chk("unstall_sel", 32'(sel), 32'd2);

    // d only, pointer wraps, then a beats d
    set_in(4'b1000, 8'h00, 8'h00, 8'h00, 8'h44);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("d_only_sel", 32'(sel), 32'd3);
    end
    set_in(4'b1001, 8'h55, 8'h00, 8'h00, 8'h44);
    step();
    chk("wrap_a_first", 32'(sel), 32'd0);
    chk("wrap_a_y", 32'(y), 32'h55);

    // reset mid-stream while b waits
    set_in(4'b0010, 8'h00, 8'h66, 8'h00, 8'h00);
    y_ready = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("midrst_valid", 32'(y_valid), 32'd0);
    chk("midrst_y", 32'(y), 32'd0);
    reset   = 1'b0;
    y_ready = 1'b1;
    step();
    chk("post_rst_b", 32'(y), 32'h66);
    chk("post_rst_sel", 32'(sel), 32'd1);

    // accept counters: 5 from a, 2 from c
    do_reset();
    set_in(4'b0001, 8'hA0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) step();
    set_in(4'b0100, 8'h00, 8'h00, 8'hC0, 8'h00);
    for (int i = 0; i < 2; i++) step();
`ifdef RR_MERGE_GRANT_CNT_EN
    chk("cnt5_a", 32'(cnt_a), 32'd5);
    chk("cnt0_b", 32'(cnt_b), 32'd0);
    chk("cnt2_c", 32'(cnt_c), 32'd2);
    chk("cnt0_d", 32'(cnt_d), 32'd0);
    do_reset();
    chk("cnt_clr", 32'({cnt_a, cnt_b} | {cnt_c, cnt_d}), 32'd0);
`endif

    // random traffic; producers hold data/valid until accepted
    do_reset();
    held_y = 8'h00;
    set_in(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!vin[i] || m_rdy[i]) begin
          vin[i] = ($urandom_range(0, 2) != 0);
          din[i] = 8'($urandom);
        end
      end
      y_ready = ($urandom_range(0, 3) != 0);
      reset   = ($urandom_range(0, 79) == 0);
      step();
      if (reset) begin
        for (int i = 0; i < 4; i++) vin[i] = 1'b0;
      end
    end
    reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
